// File: rtl/port_serial_tx.sv
// port_serial_tx: CPU-port driven async serial transmitter with one-entry holding buffer and status byte
module port_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic [7:0]  ctrl_in,
  output logic [7:0]  status_out,
  output logic        tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d;
  logic par_q, par_d, hold_par_q, hold_par_d, hold_full_q, hold_full_d;
  logic ack_q, ack_d, ovr_q, ovr_d, req_q, tx_q, tx_d;
  logic [4:0] cnt_q, cnt_d;
  logic last, load, req, accept, unused;
  assign unused = ^ctrl_in[6:2];
  assign req = ctrl_in[0] != req_q;
  assign last = baud_q == BW'(CLKS_PER_BIT - 1);
  // a request landing on the same edge the FSM drains the buffer is still accepted
  assign accept = req && (!hold_full_q || load);
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE || last) ? '0 : baud_q + 1'b1;
    idx_d = idx_q;
    cnt_d = cnt_q;
    load = 1'b0;
    case (state_q)
      IDLE: load = hold_full_q;
      START: if (last) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (last) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(DATA_W - 1)) state_d = par_q ? PARITY : STOP;
      end
      PARITY: if (last) state_d = STOP;
      STOP: if (last) begin
        cnt_d = cnt_q + 1'b1;
        load = hold_full_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) state_d = START;
    shift_d = load ? hold_q : shift_q;
    par_d = load ? hold_par_q : par_q;
    hold_d = accept ? data_in : hold_q;
    hold_par_d = accept ? ctrl_in[1] : hold_par_q;
    hold_full_d = accept || (hold_full_q && !load);
    ack_d = ack_q ^ accept;
    ovr_d = !ctrl_in[7] && (ovr_q || (req && !accept));
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[idx_d] : state_d == PARITY ? ^shift_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    req_q <= ctrl_in[0];
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      hold_q <= '0;
      hold_par_q <= 1'b0;
      hold_full_q <= 1'b0;
      ack_q <= 1'b0;
      ovr_q <= 1'b0;
      cnt_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      par_q <= par_d;
      hold_q <= hold_d;
      hold_par_q <= hold_par_d;
      hold_full_q <= hold_full_d;
      ack_q <= ack_d;
      ovr_q <= ovr_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
    end
  end
  assign tx = tx_q;
  assign status_out = {cnt_q, ovr_q, ack_q, state_q != IDLE || hold_full_q};
endmodule

// File: doc/port_serial_tx.md
Name: port_serial_tx

Overview:
Serial transmitter on the far end of the CPU output-port interface. The CPU writes a data byte to one output port and toggles a request bit on a second output port. This block captures the byte into a one-entry holding buffer and shifts it out as an asynchronous serial frame. It reports busy, acknowledge, overrun and a frame counter on a status byte that feeds one of the CPU input ports.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (must be >= 2)
DATA_W, 8, data bits per frame (fixed 8 for port compatibility)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  8  byte to send, driven from a CPU output port register
ctrl_in  input  8  control from a CPU output port: bit0 request toggle, bit1 parity enable, bit7 overrun clear (level), others ignored
status_out  output  8  to a CPU input port: bit0 busy, bit1 ack toggle, bit2 overrun sticky, bits7:3 frames-sent count mod 32
tx  output  1  serial line, idle high

Behaviour:
- Reset (synchronous, active-high; clk rising edge only):
  - tx=1; status_out=8'h00; FSM=IDLE; hold buffer empty.
  - bit/baud counters = 0; frame count = 0.
  - req_q loads ctrl_in[0] during reset, so no request is seen on release.
- Request detect:
  - req_q registers ctrl_in[0] every cycle.
  - A request occurs in any cycle where ctrl_in[0] != req_q.
  - Each toggle is exactly one request; level has no meaning.
- Accept:
  - On a request edge with hold empty, at that clock edge:
    - hold <= data_in; hold_par_en <= ctrl_in[1]; hold marked full.
    - ack (status bit1) inverts.
  - data_in and ctrl_in[1] are sampled in the same cycle the toggle is seen.
- Overrun:
  - On a request edge with hold full and not drained the same edge, the byte is dropped.
  - ack does not toggle; overrun sticky bit2 <= 1.
  - While ctrl_in[7]=1, overrun is held at 0. Clear has priority over a same-cycle set.
- Same-edge drain: if the FSM loads from hold at the same edge a request arrives, the request is accepted (hold stays full with new byte, ack toggles). No overrun.
- FSM states and transitions:
  - IDLE: tx=1. If hold full: shift <= hold, par_en <= hold_par_en, hold empty, baud=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[idx], LSB first, CLKS_PER_BIT cycles per bit. After idx 7 go PARITY if par_en, else STOP.
  - PARITY: tx = even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle, count <= count+1 (5-bit wrap 31->0).
    - If hold full, load directly and go START; no idle gap.
    - Otherwise go IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; the state/bit advances when counter == CLKS_PER_BIT-1, and the counter then returns to 0.
- Latency:
  - Request edge seen at edge N (hold loaded).
  - FSM enters START at edge N+1; tx falls at edge N+1.
  - Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- busy (bit0) = (FSM != IDLE) OR hold full.
- tx and all status bits are registered outputs; no combinational path from inputs.
- ctrl_in/data_in changes with no toggle are ignored; a frame in flight is never altered.
- Reset mid-frame: tx returns to 1 on the next edge; pending hold is discarded; count and ack clear.

Test Plan:
- CLKS_PER_BIT=4. Reset, then toggle ctrl_in[0] with data_in=8'hA5, parity off -> ack toggles at the same edge. tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. status_out ends 8'b00001_010 (count=1, busy=0).
- Parity on, data_in=8'h07 -> parity bit tx=1 between data and stop; frame lasts 44 cycles. Same test with 8'h03 -> parity bit 0.
- Toggle with 8'h11, toggle again 2 cycles later with 8'h22 -> both acked. Second START begins immediately after the first STOP's last cycle (no idle gap); count=2 after both frames.
- Three toggles in quick succession while a frame is in flight (8'h01, 8'h02, 8'h03) -> third dropped: ack toggled twice, overrun=1, only two frames sent. Hold ctrl_in[7]=1 one cycle -> overrun=0.
- Assert reset mid-DATA -> next edge: tx=1, status_out=8'h00. Release with ctrl_in[0] already 1 -> no frame starts.
- Send 32 frames -> count wraps to 0 with status_out[7:3]=0 after the 32nd STOP.
